mdr_banked: RTL and testbench

- Parametrised, registered memory data register between a DATA_W-bit bidirectional processor data bus and N_BANKS memory banks of BANK_W bits each.
- Holds transfer data in an internal register (mdr) and sequences writes and reads with fixed strobe timing.
- Supports per-bank enables and a req/ack handshake.
- Sits between the datapath's data bus and the banked SRAM in the memory subsystem.

---
 rtl/mdr_banked.sv | 134 +++++++++++++
 tb/tb_mdr_banked.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_banked.sv
// Banked memory data register: sequences strobe-timed writes and reads between a processor bus and N_BANKS SRAM banks.
// Optional per-bank even parity (mem_par, par_err) is compiled in when MDR_PARITY_EN is defined.
module mdr_banked #(
  parameter int BANK_W  = 16,
  parameter int N_BANKS = 2,
  parameter int RD_LAT  = 2,
  parameter int WR_CYC  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  inout  wire  [N_BANKS*BANK_W-1:0]   data,
  inout  wire  [N_BANKS*BANK_W-1:0]   mem_data,
  input  logic                        req,
  input  logic                        we,
  input  logic [N_BANKS-1:0]          be,
  output logic [N_BANKS-1:0]          mem_we_n,
  output logic                        mem_oe_n,
  output logic                        ack,
  output logic                        busy
`ifdef MDR_PARITY_EN
  ,
  inout  wire  [N_BANKS-1:0]          mem_par,
  output logic                        par_err
`endif
);

  localparam int DATA_W  = BANK_W * N_BANKS;
  localparam int CNT_MAX = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_mdr;
  logic                r_we_l;
  logic [N_BANKS-1:0]  r_be_l;
  logic                w_cnt_zero;
  logic                w_capture;
  logic                w_drv_data;
  logic                w_drv_mem;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_capture  = (r_state == S_READ) && w_cnt_zero;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    mem_we_n    = '1;
    mem_oe_n    = 1'b1;
    ack         = 1'b0;
    busy        = (r_state != S_IDLE);
    w_drv_data  = 1'b0;
    w_drv_mem   = 1'b0;
    case (r_state)
      S_IDLE:  if (req) w_state_nxt = we ? S_WRITE : S_READ;
      S_WRITE: begin
        w_drv_mem = 1'b1;
        mem_we_n  = ~r_be_l;
        if (w_cnt_zero) w_state_nxt = S_DONE;
      end
      S_READ: begin
        mem_oe_n = 1'b0;
        if (w_cnt_zero) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        ack         = 1'b1;
        w_drv_data  = ~r_we_l;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transfer attributes are frozen at acceptance; later req/we/be are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_mdr  <= '0;
      r_we_l <= 1'b0;
      r_be_l <= '0;
    end else begin
      if (r_state == S_IDLE && req) begin
        r_we_l <= we;
        r_be_l <= be;
        r_cnt  <= we ? CNT_W'(WR_CYC - 1) : CNT_W'(RD_LAT - 1);
        if (we) r_mdr <= data;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        for (int i = 0; i < N_BANKS; i++)
          if (r_be_l[i]) r_mdr[i*BANK_W +: BANK_W] <= mem_data[i*BANK_W +: BANK_W];
      end
    end
  end

  assign data     = w_drv_data ? r_mdr : 'z;
  assign mem_data = w_drv_mem  ? r_mdr : 'z;

`ifdef MDR_PARITY_EN
  logic [N_BANKS-1:0] w_bank_par;
  logic [N_BANKS-1:0] w_par_mis;
  logic               r_par_err;

  always_comb begin
    w_bank_par = '0;
    w_par_mis  = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      w_bank_par[i] = ^r_mdr[i*BANK_W +: BANK_W];
      w_par_mis[i]  = (^mem_data[i*BANK_W +: BANK_W]) ^ mem_par[i];
    end
  end

  // Only reads update the flag; it holds across writes until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_par_err <= 1'b0;
    else if (w_capture) r_par_err <= |(w_par_mis & r_be_l);
  end

  assign mem_par = w_drv_mem ? w_bank_par : 'z;
  assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_mdr_banked.sv
// Self-checking bench for mdr_banked: table-driven transfers with a scoreboard
// checked on ack, plus hand-written ignored-request and mid-read reset sequences.
module tb_mdr_banked;

  localparam int BANK_W  = 16;
  localparam int N_BANKS = 2;
  localparam int RD_LAT  = 2;
  localparam int WR_CYC  = 1;

  typedef struct {
    bit          we;
    bit [1:0]    be;
    logic [31:0] wdata;
    logic [31:0] memval;
    bit [1:0]    par_flip;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          par;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  be;
  wire  [31:0] data;
  wire  [31:0] mem_data;
  logic [1:0]  mem_we_n;
  logic        mem_oe_n;
  logic        ack;
  logic        busy;

  logic [31:0] tb_data;
  logic        tb_data_en;
  logic [31:0] mem_rd;
  logic        mem_keep;
  logic        mem_en;
  logic [31:0] mem_val;

  exp_t sb_q[$];
  bit   exp_par;
  int   n_checks;
  int   n_pass;
  vec_t vecs[10];

  assign data = tb_data_en ? tb_data : 'z;

  // Memory model: returns mem_rd while output-enabled, otherwise parks the bus at 0 when asked.
  always_comb begin
    mem_en  = !mem_oe_n || mem_keep;
    mem_val = !mem_oe_n ? mem_rd : 32'h0;
  end
  assign mem_data = mem_en ? mem_val : 'z;

`ifdef MDR_PARITY_EN
  wire  [1:0] mem_par;
  logic       par_err;
  logic [1:0] mem_par_rd;
  assign mem_par = !mem_oe_n ? mem_par_rd : 'z;
`endif

  mdr_banked #(
    .BANK_W (BANK_W),
    .N_BANKS(N_BANKS),
    .RD_LAT (RD_LAT),
    .WR_CYC (WR_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .mem_data(mem_data),
    .req     (req),
    .we      (we),
    .be      (be),
    .mem_we_n(mem_we_n),
    .mem_oe_n(mem_oe_n),
    .ack     (ack),
    .busy    (busy)
`ifdef MDR_PARITY_EN
    ,
    .mem_par (mem_par),
    .par_err (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard consumer: every ack must match the oldest outstanding transfer.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {31'b0, ack}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_read) check("ack_rd_data", data, e.data);
        else           check("ack_wr_data_bus", data, 32'h0);
`ifdef MDR_PARITY_EN
        check("ack_par_err", {31'b0, par_err}, {31'b0, e.par});
`endif
      end
    end
  end

  // Entered and left at negedge+1; hold keeps req asserted (with different we/be) until DONE.
  task automatic do_xfer(input vec_t v, input bit hold);
    int   lat;
    exp_t e;
    lat        = v.we ? WR_CYC : RD_LAT;
    req        = 1'b1;
    we         = v.we;
    be         = v.be;
    tb_data    = v.we ? v.wdata : 32'h0;
    tb_data_en = 1'b1;
    mem_rd     = v.memval;
    mem_keep   = !v.we;
`ifdef MDR_PARITY_EN
    mem_par_rd = {^v.memval[31:16], ^v.memval[15:0]} ^ v.par_flip;
`endif
    if (!v.we) exp_par = |(v.be & v.par_flip);
    e.is_read = !v.we;
    e.data    = v.exp_data;
    e.par     = exp_par;
    sb_q.push_back(e);

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tb_data = 32'h0;
        if (hold) begin
          we = ~v.we;
          be = ~v.be;
        end else begin
          req = 1'b0;
        end
      end
      if (c == lat + 1) req = 1'b0;
      #1;
      check("busy", {31'b0, busy}, 32'h1);
      if (c <= lat) begin
        check("ack_early", {31'b0, ack}, 32'h0);
        check("mem_oe_n", {31'b0, mem_oe_n}, v.we ? 32'h1 : 32'h0);
        check("mem_we_n", {30'b0, mem_we_n}, v.we ? {30'b0, ~v.be} : 32'h3);
        check("data_not_driven", data, 32'h0);
        if (v.we) check("mem_data_wr", mem_data, v.wdata);
        if (c == lat && !v.we) tb_data_en = 1'b0;
      end else begin
        check("ack_done", {31'b0, ack}, 32'h1);
        check("done_strobes", {29'b0, mem_oe_n, mem_we_n}, 32'h7);
      end
    end

    @(negedge clk);
    tb_data_en = 1'b1;
    tb_data    = 32'h0;
    mem_keep   = 1'b1;
    #1;
    check("idle_busy", {31'b0, busy}, 32'h0);
    check("idle_ack", {31'b0, ack}, 32'h0);
    check("idle_data_hiz", data, 32'h0);
    check("idle_mem_hiz", mem_data, 32'h0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    exp_par    = 1'b0;
    rst_n      = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    be         = 2'b00;
    tb_data    = 32'h0;
    tb_data_en = 1'b1;
    mem_rd     = 32'h0;
    mem_keep   = 1'b1;
`ifdef MDR_PARITY_EN
    mem_par_rd = 2'b00;
`endif

    //            we    be     wdata         memval        flip   exp_data
    vecs[0] = '{1'b1, 2'b11, 32'hDEADBEEF, 32'h00000000, 2'b00, 32'h00000000};
    vecs[1] = '{1'b0, 2'b11, 32'h00000000, 32'h12345678, 2'b00, 32'h12345678};
    vecs[2] = '{1'b1, 2'b11, 32'hAAAA5555, 32'h00000000, 2'b00, 32'h00000000};
    vecs[3] = '{1'b0, 2'b10, 32'h00000000, 32'h11112222, 2'b00, 32'h11115555};
    vecs[4] = '{1'b0, 2'b01, 32'h00000000, 32'h9999CCCC, 2'b00, 32'h1111CCCC};
    vecs[5] = '{1'b1, 2'b00, 32'h0F0F0F0F, 32'h00000000, 2'b00, 32'h00000000};
    vecs[6] = '{1'b0, 2'b00, 32'h00000000, 32'hFFFFFFFF, 2'b00, 32'h0F0F0F0F};
    vecs[7] = '{1'b0, 2'b11, 32'h00000000, 32'h00010000, 2'b10, 32'h00010000};
    vecs[8] = '{1'b1, 2'b01, 32'h76543210, 32'h00000000, 2'b00, 32'h00000000};
    vecs[9] = '{1'b0, 2'b11, 32'h00000000, 32'h00000000, 2'b00, 32'h00000000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_strobes", {29'b0, mem_oe_n, mem_we_n}, 32'h7);
    check("rst_data_hiz", data, 32'h0);
    check("rst_mem_hiz", mem_data, 32'h0);
`ifdef MDR_PARITY_EN
    check("rst_par_err", {31'b0, par_err}, 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 10; i++) do_xfer(vecs[i], 1'b0);

    // Requests while busy must neither queue nor produce a second ack.
    do_xfer('{1'b0, 2'b11, 32'h0, 32'h5A5AA5A5, 2'b00, 32'h5A5AA5A5}, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("no_extra_ack", {31'b0, ack}, 32'h0);
      check("no_extra_busy", {31'b0, busy}, 32'h0);
    end

    // Reset in cycle 1 of a read: abandoned, no ack, mdr cleared.
    req      = 1'b1;
    we       = 1'b0;
    be       = 2'b11;
    mem_rd   = 32'hCAFEF00D;
    mem_keep = 1'b1;
    @(negedge clk);
    req = 1'b0;
    #1;
    check("midrd_busy", {31'b0, busy}, 32'h1);
    check("midrd_oe", {31'b0, mem_oe_n}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrd_rst_busy", {31'b0, busy}, 32'h0);
    check("midrd_rst_oe", {31'b0, mem_oe_n}, 32'h1);
    check("midrd_rst_ack", {31'b0, ack}, 32'h0);
    rst_n   = 1'b1;
    exp_par = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_ack", {31'b0, ack}, 32'h0);
    end
    do_xfer('{1'b0, 2'b00, 32'h0, 32'hFFFFFFFF, 2'b00, 32'h00000000}, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
